// File: rtl/mem_if_pkg.sv
// Shared definitions for the 128-bit mem_* request/response interface.
// The LFSR constants are reused by traffic generators so stall patterns match.
package mem_if_pkg;

   localparam int MEM_DATA_W = 128;
   localparam int MEM_MASK_W = 16;
   localparam int MEM_ID_W   = 16;
   localparam int MEM_ADDR_W = 32;

   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   // Right-shifting Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

   typedef struct packed {
      logic                valid;
      logic [MEM_ID_W-1:0] id;
      logic                error;
   } resp_tag_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {^(state & LFSR_TAP_MASK), state[15:1]};
   endfunction

endpackage

// File: rtl/mem_sram_responder_if.sv
// Request/response bundle of the mem_* bus; master drives requests, slave answers.
interface mem_sram_responder_if;
   import mem_if_pkg::*;

   logic [MEM_MASK_W-1:0] mem_wr_i;
   logic                  mem_rd_i;
   logic [MEM_ADDR_W-1:0] mem_addr_i;
   logic [MEM_DATA_W-1:0] mem_write_data_i;
   logic [MEM_ID_W-1:0]   mem_req_id_i;
   logic                  mem_accept_o;
   logic                  mem_ack_o;
   logic                  mem_error_o;
   logic [MEM_ID_W-1:0]   mem_resp_id_o;
   logic [MEM_DATA_W-1:0] mem_read_data_o;

   modport master (
      output mem_wr_i, mem_rd_i, mem_addr_i, mem_write_data_i, mem_req_id_i,
      input  mem_accept_o, mem_ack_o, mem_error_o, mem_resp_id_o, mem_read_data_o
   );

   modport slave (
      input  mem_wr_i, mem_rd_i, mem_addr_i, mem_write_data_i, mem_req_id_i,
      output mem_accept_o, mem_ack_o, mem_error_o, mem_resp_id_o, mem_read_data_o
   );

endinterface

// File: rtl/mem_resp_delay.sv
// Fixed-latency response pipeline of {valid, id, error}; data enters at stage 1.
// Each stage only reloads on a valid entry, so the outputs hold between acks.
module mem_resp_delay
   import mem_if_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_valid,
   input  logic [MEM_ID_W-1:0]   i_id,
   input  logic                  i_error,
   input  logic [MEM_DATA_W-1:0] i_data,
   output logic                  o_valid,
   output logic [MEM_ID_W-1:0]   o_id,
   output logic                  o_error,
   output logic [MEM_DATA_W-1:0] o_data
);

   resp_tag_t             w_tag  [0:LATENCY];
   logic [MEM_DATA_W-1:0] w_data [1:LATENCY];

   assign w_tag[0]  = {i_valid, i_id, i_error};
   assign w_data[1] = i_data;

   for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
      resp_tag_t r_tag;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_tag <= '0;
         end else begin
            r_tag.valid <= w_tag[k-1].valid;
            if (w_tag[k-1].valid) begin
               r_tag.id    <= w_tag[k-1].id;
               r_tag.error <= w_tag[k-1].error;
            end
         end
      end

      assign w_tag[k] = r_tag;

      // Stage 1 data is the responder's registered array read.
      if (k > 1) begin : g_data
         logic [MEM_DATA_W-1:0] r_data;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_data <= '0;
            end else if (w_tag[k-1].valid) begin
               r_data <= w_data[k-1];
            end
         end

         assign w_data[k] = r_data;
      end
   end

   assign o_valid = w_tag[LATENCY].valid;
   assign o_id    = w_tag[LATENCY].id;
   assign o_error = w_tag[LATENCY].error;
   assign o_data  = w_data[LATENCY];

endmodule

// File: rtl/mem_sram_responder.sv
// SRAM-backed responder for the mem_* bus with programmable latency,
// an outstanding-request limit and optional LFSR-driven accept stalls.
module mem_sram_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_BITS       = 10,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter bit STALL_EN        = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   mem_sram_responder_if.slave  mem_bus
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [MEM_DATA_W-1:0] r_mem [DEPTH];
   logic [MEM_DATA_W-1:0] r_rd_data;
   logic [3:0]            r_outstanding;
   logic [15:0]           r_lfsr;

   logic                  w_is_write;
   logic                  w_is_read;
   logic                  w_accept;
   logic                  w_fire;
   logic                  w_error;
   logic                  w_ack;
   logic [ADDR_BITS-1:0]  w_line;
   logic [MEM_ADDR_W-1:0] w_addr_hi;

   assign w_is_write = |mem_bus.mem_wr_i;
   assign w_is_read  = mem_bus.mem_rd_i;
   assign w_line     = mem_bus.mem_addr_i[ADDR_BITS+3:4];
   assign w_addr_hi  = mem_bus.mem_addr_i >> (ADDR_BITS + 4);
   assign w_error    = (w_addr_hi != {MEM_ADDR_W{1'b0}}) | (w_is_read & w_is_write);

   // Accept is a pure function of state so initiators never see a combinational loop.
   assign w_accept = ~reset & (r_outstanding < 4'(MAX_OUTSTANDING)) & ~(STALL_EN & r_lfsr[0]);
   assign w_fire   = w_accept & (w_is_write | w_is_read);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_outstanding <= 4'd0;
      end else begin
         case ({w_fire, w_ack})
            2'b10:   r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= r_outstanding - 4'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Array contents survive reset on purpose: committed writes stay readable.
   always_ff @(posedge clock) begin
      if (w_fire && !w_error) begin
         for (int b = 0; b < MEM_MASK_W; b++) begin
            if (mem_bus.mem_wr_i[b]) begin
               r_mem[w_line][8*b +: 8] <= mem_bus.mem_write_data_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_data <= '0;
      end else if (w_fire) begin
         r_rd_data <= (w_is_read && !w_error) ? r_mem[w_line] : {MEM_DATA_W{1'b0}};
      end
   end

   mem_resp_delay #(
      .LATENCY (LATENCY)
   ) u_resp_delay (
      .clock   (clock),
      .reset   (reset),
      .i_valid (w_fire),
      .i_id    (mem_bus.mem_req_id_i),
      .i_error (w_error),
      .i_data  (r_rd_data),
      .o_valid (w_ack),
      .o_id    (mem_bus.mem_resp_id_o),
      .o_error (mem_bus.mem_error_o),
      .o_data  (mem_bus.mem_read_data_o)
   );

   assign mem_bus.mem_accept_o = w_accept;
   assign mem_bus.mem_ack_o    = w_ack;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Bench for mem_sram_responder: three configurations behind one stimulus bus,
// a vector table for directed cases and an in-order scoreboard for everything.
module tb_mem_sram_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]   sel;
   logic [15:0]  t_wr;
   logic         t_rd;
   logic [31:0]  t_addr;
   logic [127:0] t_wdata;
   logic [15:0]  t_id;

   logic         m_acc, m_ack, m_err;
   logic [15:0]  m_id;
   logic [127:0] m_data;

   int total = 0;
   int bad   = 0;

   mem_sram_responder_if if_a ();
   mem_sram_responder_if if_b ();
   mem_sram_responder_if if_c ();

   mem_sram_responder #(.ADDR_BITS(10), .LATENCY(4), .MAX_OUTSTANDING(4), .STALL_EN(1'b0))
      dut_a (.clock(clk), .reset(rst), .mem_bus(if_a));
   mem_sram_responder #(.ADDR_BITS(10), .LATENCY(8), .MAX_OUTSTANDING(2), .STALL_EN(1'b0))
      dut_b (.clock(clk), .reset(rst), .mem_bus(if_b));
   mem_sram_responder #(.ADDR_BITS(10), .LATENCY(6), .MAX_OUTSTANDING(4), .STALL_EN(1'b1))
      dut_c (.clock(clk), .reset(rst), .mem_bus(if_c));

   assign if_a.mem_wr_i = (sel == 2'd0) ? t_wr : 16'h0;
   assign if_a.mem_rd_i = (sel == 2'd0) ? t_rd : 1'b0;
   assign if_a.mem_addr_i = t_addr;
   assign if_a.mem_write_data_i = t_wdata;
   assign if_a.mem_req_id_i = t_id;
   assign if_b.mem_wr_i = (sel == 2'd1) ? t_wr : 16'h0;
   assign if_b.mem_rd_i = (sel == 2'd1) ? t_rd : 1'b0;
   assign if_b.mem_addr_i = t_addr;
   assign if_b.mem_write_data_i = t_wdata;
   assign if_b.mem_req_id_i = t_id;
   assign if_c.mem_wr_i = (sel == 2'd2) ? t_wr : 16'h0;
   assign if_c.mem_rd_i = (sel == 2'd2) ? t_rd : 1'b0;
   assign if_c.mem_addr_i = t_addr;
   assign if_c.mem_write_data_i = t_wdata;
   assign if_c.mem_req_id_i = t_id;

   always_comb begin
      m_acc = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_id = 16'h0; m_data = 128'h0;
      case (sel)
         2'd0: begin m_acc = if_a.mem_accept_o; m_ack = if_a.mem_ack_o; m_err = if_a.mem_error_o;
                     m_id = if_a.mem_resp_id_o; m_data = if_a.mem_read_data_o; end
         2'd1: begin m_acc = if_b.mem_accept_o; m_ack = if_b.mem_ack_o; m_err = if_b.mem_error_o;
                     m_id = if_b.mem_resp_id_o; m_data = if_b.mem_read_data_o; end
         2'd2: begin m_acc = if_c.mem_accept_o; m_ack = if_c.mem_ack_o; m_err = if_c.mem_error_o;
                     m_id = if_c.mem_resp_id_o; m_data = if_c.mem_read_data_o; end
         default: begin m_acc = 1'b0; end
      endcase
   end

   function automatic int lat_of(input logic [1:0] s);
      case (s) 2'd0: return 4; 2'd1: return 8; default: return 6; endcase
   endfunction
   function automatic int max_of(input logic [1:0] s);
      case (s) 2'd1: return 2; default: return 4; endcase
   endfunction
   function automatic bit stall_of(input logic [1:0] s);
      return (s == 2'd2);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0]  id;
      bit           err;
      bit           chk;
      logic [127:0] data;
      int           due;
   } exp_t;

   exp_t         expq[$];
   logic [127:0] mdl_mem[int];
   int           cyc = 0;
   int           outst = 0;
   logic [15:0]  lfsr_m = 16'hACE1;

   always @(posedge clk) begin
      if (rst) begin
         cyc = 0;
         lfsr_m = 16'hACE1;
      end else begin
         cyc = cyc + 1;
         lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      end
   end

   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      int key;
      logic [127:0] tmp;
      bit exp_acc;
      if (rst) begin
         check("rst_accept", m_acc, 1'b0);
         check("rst_ack", m_ack, 1'b0);
         check("rst_err", m_err, 1'b0);
         check("rst_id", m_id, 16'h0);
         check("rst_data", m_data, 128'h0);
         expq.delete();
         outst = 0;
      end else begin
         exp_acc = (outst < max_of(sel)) && !(stall_of(sel) && lfsr_m[0]);
         check("accept", m_acc, exp_acc);
         if (expq.size() > 0 && expq[0].due < cyc) begin
            fail("ack_missing");
            void'(expq.pop_front());
         end
         if (m_ack) begin
            if (expq.size() == 0) begin
               fail("ack_spurious");
            end else begin
               got = expq.pop_front();
               check("ack_cycle", cyc, got.due);
               check("resp_id", m_id, got.id);
               check("resp_err", m_err, got.err);
               if (got.chk) check("resp_data", m_data, got.data);
            end
            if (outst > 0) outst--;
         end
         if ((t_rd || t_wr != 16'h0) && m_acc) begin
            key = int'(sel) * 4096 + int'(t_addr[13:4]);
            e.id = t_id;
            e.err = ((t_addr >> 14) != 32'h0) || (t_rd && t_wr != 16'h0);
            e.due = cyc + lat_of(sel);
            e.data = 128'h0;
            e.chk = 1'b1;
            if (!e.err && t_wr != 16'h0) begin
               if (t_wr == 16'hFFFF) begin
                  mdl_mem[key] = t_wdata;
               end else if (mdl_mem.exists(key)) begin
                  tmp = mdl_mem[key];
                  for (int b = 0; b < 16; b++)
                     if (t_wr[b]) tmp[8*b +: 8] = t_wdata[8*b +: 8];
                  mdl_mem[key] = tmp;
               end
            end else if (!e.err) begin
               if (mdl_mem.exists(key)) e.data = mdl_mem[key];
               else e.chk = 1'b0;
            end
            expq.push_back(e);
            outst++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      t_wr = 16'h0; t_rd = 1'b0;
   endtask

   task automatic do_reset(input logic [1:0] s);
      @(posedge clk); #1;
      rst = 1'b1;
      idle();
      sel = s;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic issue(input logic [15:0] w, input logic r, input logic [31:0] a,
                        input logic [127:0] d, input logic [15:0] i);
      bit got = 1'b0;
      t_wr = w; t_rd = r; t_addr = a; t_wdata = d; t_id = i;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (m_acc) got = 1'b1;
      end
      @(posedge clk); #1;
      if (!got) begin
         fail("accept_timeout");
         idle();
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && expq.size() != 0; k++) @(negedge clk);
      if (expq.size() != 0) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   task automatic do_req(input logic [15:0] w, input logic r, input logic [31:0] a,
                         input logic [127:0] d, input logic [15:0] i,
                         output logic e_o, output logic [15:0] id_o,
                         output logic [127:0] d_o, output int lat);
      int acc_cyc = 0;
      bit got = 1'b0;
      lat = -1; e_o = 1'b0; id_o = 16'h0; d_o = 128'h0;
      t_wr = w; t_rd = r; t_addr = a; t_wdata = d; t_id = i;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (m_acc) begin got = 1'b1; acc_cyc = cyc; end
      end
      @(posedge clk); #1;
      idle();
      if (got) begin
         got = 1'b0;
         for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (m_ack) begin
               got = 1'b1; lat = cyc - acc_cyc; e_o = m_err; id_o = m_id; d_o = m_data;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [15:0]  wr;
      logic         rd;
      logic [31:0]  addr;
      logic [127:0] wdata;
      logic         err;
      logic [127:0] rdata;
   } vec_t;

   vec_t vt[16];

   initial begin
      logic [127:0] d1, d2, aa, p16, d1b;
      logic         ge;
      logic [15:0]  gid;
      logic [127:0] gd;
      int           glat;
      int           accq[$];
      int           ack_after;
      bit           a;

      d1  = 128'hffeeddccbbaa99887766554433221100;
      d2  = 128'h0123456789abcdeffedcba9876543210;
      aa  = {16{8'hAA}};
      p16 = {{12{8'hAA}}, 32'h11223344};
      d1b = 128'h77eeddccbbaa99887766554433221100;

      vt[0]  = '{16'hFFFF, 1'b0, 32'h0000_0000, d1,             1'b0, 128'h0};
      vt[1]  = '{16'h0000, 1'b1, 32'h0000_0000, 128'h0,         1'b0, d1};
      vt[2]  = '{16'hFFFF, 1'b0, 32'h0000_0010, aa,             1'b0, 128'h0};
      vt[3]  = '{16'h000F, 1'b0, 32'h0000_0010, 128'h11223344,  1'b0, 128'h0};
      vt[4]  = '{16'h0000, 1'b1, 32'h0000_0010, 128'h0,         1'b0, p16};
      vt[5]  = '{16'h0000, 1'b1, 32'h0001_0000, 128'h0,         1'b1, 128'h0};
      vt[6]  = '{16'h0000, 1'b1, 32'h0000_0000, 128'h0,         1'b0, d1};
      vt[7]  = '{16'hFFFF, 1'b1, 32'h0000_0000, 128'h0,         1'b1, 128'h0};
      vt[8]  = '{16'h0000, 1'b1, 32'h0000_0000, 128'h0,         1'b0, d1};
      vt[9]  = '{16'h8000, 1'b0, 32'h0000_0000, {8'h77, 120'h0}, 1'b0, 128'h0};
      vt[10] = '{16'h0000, 1'b1, 32'h0000_000F, 128'h0,         1'b0, d1b};
      vt[11] = '{16'hFFFF, 1'b0, 32'h0000_3FF0, d2,             1'b0, 128'h0};
      vt[12] = '{16'hFFFF, 1'b0, 32'hFFFF_FFF0, 128'h0,         1'b1, 128'h0};
      vt[13] = '{16'h0000, 1'b1, 32'h0000_3FFC, 128'h0,         1'b0, d2};
      vt[14] = '{16'h0000, 1'b1, 32'h0000_4000, 128'h0,         1'b1, 128'h0};
      vt[15] = '{16'h0000, 1'b1, 32'h0000_0010, 128'h0,         1'b0, p16};

      sel = 2'd0; t_addr = 32'h0; t_wdata = 128'h0; t_id = 16'h0;
      idle();

      // Directed table on LATENCY=4, MAX_OUTSTANDING=4
      do_reset(2'd0);
      for (int i = 0; i < 16; i++) begin
         do_req(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, 16'(i + 1), ge, gid, gd, glat);
         check($sformatf("vec%0d_lat", i), glat, 4);
         check($sformatf("vec%0d_id", i), gid, 16'(i + 1));
         check($sformatf("vec%0d_err", i), ge, vt[i].err);
         check($sformatf("vec%0d_data", i), gd, vt[i].rdata);
      end
      drain();

      // Continuous reads on LATENCY=8, MAX_OUTSTANDING=2
      do_reset(2'd1);
      t_addr = 32'h0; t_rd = 1'b1; t_id = 16'h0100;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         a = m_acc;
         if (a) accq.push_back(cyc);
         @(posedge clk); #1;
         if (a) t_id = t_id + 16'd1;
      end
      idle();
      drain();
      check("full_accept_count", accq.size(), 6);
      if (accq.size() >= 5) begin
         check("full_acc0", accq[0], 0);
         check("full_acc1", accq[1], 1);
         check("full_acc2", accq[2], 9);
         check("full_acc4", accq[4], 18);
      end

      // Random traffic with stalls on LATENCY=6, MAX_OUTSTANDING=4
      do_reset(2'd2);
      for (int l = 0; l < 8; l++)
         issue(16'hFFFF, 1'b0, 32'(l * 16), {$urandom, $urandom, $urandom, $urandom}, 16'(16'h200 + l));
      for (int n = 0; n < 100; n++) begin
         int op;
         logic [15:0] m;
         logic [31:0] ad;
         op = $urandom_range(0, 9);
         ad = 32'($urandom_range(0, 7) * 16) | 32'($urandom_range(0, 15));
         m = 16'($urandom);
         if (m == 16'h0) m = 16'h0001;
         if (op < 5)       issue(16'h0, 1'b1, ad, 128'h0, 16'(16'h300 + n));
         else if (op < 9)  issue(m, 1'b0, ad, {$urandom, $urandom, $urandom, $urandom}, 16'(16'h300 + n));
         else if (n[0])    issue(16'h0, 1'b1, ad | 32'h0100_0000, 128'h0, 16'(16'h300 + n));
         else              issue(m, 1'b1, ad, {$urandom, $urandom, $urandom, $urandom}, 16'(16'h300 + n));
      end
      idle();
      drain();

      // Reset with requests in flight: they must vanish, memory must not
      for (int k = 0; k < 40 && outst < 3; k++)
         issue(16'h0, 1'b1, 32'($urandom_range(0, 7) * 16), 128'h0, 16'(16'h400 + k));
      check("outstanding_before_reset", (outst >= 3), 1'b1);
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ack_after = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (m_ack) ack_after++;
      end
      check("ack_after_reset", ack_after, 0);
      @(posedge clk); #1;
      for (int l = 0; l < 8; l++)
         issue(16'h0, 1'b1, 32'(l * 16), 128'h0, 16'(16'h500 + l));
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_sram_responder.md
# mem_sram_responder

On-chip SRAM-backed responder for the 128-bit `mem_*` request/response interface that `ddr3_core` serves. It lets initiators such as DMA, capture and correlator front-ends run in simulation and on FPGA with no DDR3 PHY or external memory. It adds programmable response latency, an outstanding-request limit and optional pseudo-random accept stalls, so that initiator wait loops get exercised.

## Interface
Parameters:
- `ADDR_BITS`, default 10: log2 of depth in 128-bit lines. Line index is `mem_addr_i[ADDR_BITS+3:4]`.
- `LATENCY`, default 4: cycles from accept edge to ack. Legal range is ≥1.
- `MAX_OUTSTANDING`, default 4: maximum number of accepted requests not yet acked. Legal range is 1..15.
- `STALL_EN`, default 0: when 1, an LFSR randomly deasserts accept.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `mem_wr_i` in 16: byte write mask. Any bit set means a write request.
- `mem_rd_i` in 1: read request.
- `mem_addr_i` in 32: byte address. Bits [3:0] are ignored.
- `mem_write_data_i` in 128: write data. Byte i is bits [8i+7:8i].
- `mem_req_id_i` in 16: request tag.
- `mem_accept_o` out 1: request accepted at this rising edge.
- `mem_ack_o` out 1: one-cycle response strobe.
- `mem_error_o` out 1: the response is an error.
- `mem_resp_id_o` out 16: tag of the request being acknowledged.
- `mem_read_data_o` out 128: read data. It is 0 for write and error responses.

## Operation
- A request is valid when `|mem_wr_i | mem_rd_i`. It is accepted at a rising edge where the request is valid and `mem_accept_o`=1.
- `mem_accept_o` depends only on state, never on the request inputs. It equals `(outstanding < MAX_OUTSTANDING) & ~(STALL_EN & lfsr[0])`.
- `outstanding` is a 4-bit counter:
  - +1 on accept, −1 on ack.
  - Accept and ack on the same edge leave it unchanged.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  - Advances every cycle.
- Error conditions (evaluated at accept):
  - `mem_addr_i[31:ADDR_BITS+4]` ≠ 0 (out of range), or
  - both `mem_rd_i` and a nonzero `mem_wr_i`.
  - Error requests perform no write and return data 0.
- Write: the enabled byte lanes are committed to the array at the accept edge.
- Read: the array is sampled at the accept edge and sees every write accepted earlier. Only one request is accepted per cycle, so there are no same-edge hazards.
- Responses:
  - Returned strictly in acceptance order.
  - There is no response back-pressure.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- A request accepted at edge N is acked in the cycle following edge N+LATENCY−1. With LATENCY=1, ack is high in the cycle right after the accept edge.
- Back-to-back accepts produce back-to-back acks.
- `mem_resp_id_o`, `mem_error_o` and `mem_read_data_o`:
  - Registered.
  - Valid while `mem_ack_o`=1.
  - Hold their last value otherwise.
- Reset values: `mem_accept_o` 0 while reset is asserted, and `mem_ack_o`, `mem_error_o`, `mem_resp_id_o` and `mem_read_data_o` 0.
- On release, accept may assert in the first cycle, subject to the LFSR.
- Reset mid-operation clears the delay pipeline, `outstanding` and the LFSR. In-flight requests are dropped with no ack. Writes already committed remain.
- Full condition: at `outstanding`=MAX_OUTSTANDING, accept is 0. It reasserts in the cycle after the ack edge.

## Structure
- Shared package `mem_if_pkg`:
  - `MEM_DATA_W`=128, `MEM_MASK_W`=16, `MEM_ID_W`=16, `MEM_ADDR_W`=32.
  - LFSR seed and tap constants, which are shared with future traffic generators.
- Top level: array with byte-enable write and registered read, the accept logic, the outstanding counter and the LFSR.
- Sub-module `mem_resp_delay`: LATENCY-stage shift register of {valid, id, error}. Data joins at the stage aligned with the registered array read (stage 1). The final stage drives the outputs.

## Test plan
1. Write addr 0, data 128'hffeeddccbbaa99887766554433221100, mask 16'hFFFF, id 1. Then read addr 0, id 2. Expect: ack after LATENCY, `mem_resp_id_o`=2, error 0, data matches.
2. Write addr 16 with all bytes 8'hAA. Then write addr 16, mask 16'h000F, data 128'h...11223344. Then read. Expect: 128'hAAAA_..._AAAA_11223344.
3. ADDR_BITS=10, read addr 32'h0001_0000. Expect: error 1, data 0, ack at LATENCY. A subsequent read of line 0 is unchanged.
4. `mem_rd_i`=1 and `mem_wr_i`=16'hFFFF together. Expect: error ack and no array write.
5. LATENCY=8, MAX_OUTSTANDING=2, reads presented continuously. Expect: accepts at edges 0 and 1, accept low until the first ack, ids returned in order, never more than 2 outstanding.
6. STALL_EN=1, 100 random reads and writes against a scoreboard. Assert reset with 3 outstanding. Expect: no ack after reset, counter 0, committed writes readable after release.
